// File: rtl/bf_seq_gen.sv
// Throttled producer sequence generator: emits cfg_count incrementing data words on a
// srdy/drdy handshake, with offers gated by a rotating srdy_pat throttle pattern.
module bf_seq_gen #(
  parameter int unsigned width   = 8,
  parameter int unsigned abits   = 3,
  parameter int unsigned pat_dep = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [15:0]        cfg_count,
  input  logic [width-1:0]   cfg_seed,
  input  logic [abits-1:0]   cfg_addr,
  input  logic [pat_dep-1:0] srdy_pat,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [abits-1:0]   p_addr,
  output logic [width-1:0]   p_data,
  output logic               done,
  output logic [15:0]        xfer_cnt
);

  localparam int unsigned PtrW = (pat_dep > 1) ? $clog2(pat_dep) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;
  logic [width-1:0] p_data_q, p_data_d;
  logic [abits-1:0] p_addr_q, p_addr_d;
  logic             p_srdy_q, p_srdy_d;
  logic             done_q, done_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;

  logic            hold;
  logic            xfer;
  logic [PtrW-1:0] ptr_inc;

  // An offered word that the consumer has not accepted freezes data, valid and the pattern.
  assign hold    = p_srdy_q & ~p_drdy;
  assign xfer    = p_srdy_q & p_drdy;
  assign ptr_inc = (ptr_q == PtrW'(pat_dep - 1)) ? '0 : ptr_q + PtrW'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    xfer_cnt_d = xfer_cnt_q;
    p_data_d   = p_data_q;
    p_addr_d   = p_addr_q;
    p_srdy_d   = p_srdy_q;
    done_d     = done_q;
    ptr_d      = ptr_q;

    unique case (state_q)
      StIdle, StDone: begin
        p_srdy_d = 1'b0;
        if (start) begin
          state_d    = StRun;
          count_d    = cfg_count;
          p_data_d   = cfg_seed;
          p_addr_d   = cfg_addr;
          xfer_cnt_d = '0;
          ptr_d      = '0;
          done_d     = 1'b0;
        end
      end

      StRun: begin
        if (!hold) begin
          if (xfer) begin
            p_data_d   = p_data_q + width'(1);
            xfer_cnt_d = xfer_cnt_q + 16'd1;
          end
          ptr_d = ptr_inc;
          // No words left after this edge: covers both the final transfer and cfg_count == 0.
          if (xfer_cnt_d == count_q) begin
            state_d  = StDone;
            done_d   = 1'b1;
            p_srdy_d = 1'b0;
          end else begin
            p_srdy_d = srdy_pat[ptr_q];
          end
        end
      end

      default: begin
        state_d  = StIdle;
        p_srdy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      xfer_cnt_q <= '0;
      p_data_q   <= '0;
      p_addr_q   <= '0;
      p_srdy_q   <= 1'b0;
      done_q     <= 1'b0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      xfer_cnt_q <= xfer_cnt_d;
      p_data_q   <= p_data_d;
      p_addr_q   <= p_addr_d;
      p_srdy_q   <= p_srdy_d;
      done_q     <= done_d;
      ptr_q      <= ptr_d;
    end
  end

  assign p_srdy   = p_srdy_q;
  assign p_data   = p_data_q;
  assign p_addr   = p_addr_q;
  assign done     = done_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_bf_seq_gen.sv
// Directed self-checking bench for bf_seq_gen (width=8, abits=3, pat_dep=8).
module tb_bf_seq_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] cfg_count;
  logic [7:0]  cfg_seed;
  logic [2:0]  cfg_addr;
  logic [7:0]  srdy_pat;
  logic        p_srdy;
  logic        p_drdy;
  logic [2:0]  p_addr;
  logic [7:0]  p_data;
  logic        done;
  logic [15:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  bf_seq_gen #(
    .width  (8),
    .abits  (3),
    .pat_dep(8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .cfg_count(cfg_count),
    .cfg_seed (cfg_seed),
    .cfg_addr (cfg_addr),
    .srdy_pat (srdy_pat),
    .p_srdy   (p_srdy),
    .p_drdy   (p_drdy),
    .p_addr   (p_addr),
    .p_data   (p_data),
    .done     (done),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Start pulse applied for one edge; returns at the negedge after the start edge.
  task automatic kick(input logic [15:0] cnt, input logic [7:0] seed, input logic [2:0] addr);
    cfg_count = cnt;
    cfg_seed  = seed;
    cfg_addr  = addr;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; cfg_count = '0; cfg_seed = '0; cfg_addr = '0;
    srdy_pat = 8'hFF; p_drdy = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({p_srdy, done, p_data, p_addr, xfer_cnt} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got srdy=%b done=%b data=%h addr=%h cnt=%0d, expected all 0",
               p_srdy, done, p_data, p_addr, xfer_cnt);
    end
    checks++;
    if (dut.ptr_q !== 3'd0) begin
      errors++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_q);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (p_srdy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got srdy=%b done=%b expected 0 0", p_srdy, done);
    end
  endtask

  task automatic test_basic();
    srdy_pat = 8'hFF; p_drdy = 1'b1;
    kick(16'd4, 8'h10, 3'd3);
    checks++;
    if (p_srdy !== 1'b0 || xfer_cnt !== 16'd0 || p_addr !== 3'd3) begin
      errors++;
      $display("FAIL basic_launch: got srdy=%b cnt=%0d addr=%0d expected 0 0 3", p_srdy, xfer_cnt,
               p_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (p_srdy !== 1'b1 || p_data !== 8'(8'h10 + i) || p_addr !== 3'd3) begin
        errors++;
        $display("FAIL basic_word%0d: got srdy=%b data=%h addr=%0d expected 1 %h 3", i, p_srdy,
                 p_data, p_addr, 8'(8'h10 + i));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || p_srdy !== 1'b0 || xfer_cnt !== 16'd4) begin
      errors++;
      $display("FAIL basic_done: got done=%b srdy=%b cnt=%0d expected 1 0 4", done, p_srdy,
               xfer_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || p_srdy !== 1'b0 || xfer_cnt !== 16'd4 || p_data !== 8'h14 ||
        p_addr !== 3'd3) begin
      errors++;
      $display("FAIL done_hold: got done=%b srdy=%b cnt=%0d data=%h addr=%0d expected 1 0 4 14 3",
               done, p_srdy, xfer_cnt, p_data, p_addr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_data [3];
    exp_data[0] = 8'hFE; exp_data[1] = 8'hFF; exp_data[2] = 8'h00;
    srdy_pat = 8'hFF; p_drdy = 1'b1;
    kick(16'd3, 8'hFE, 3'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (p_srdy !== 1'b1 || p_data !== exp_data[i]) begin
        errors++;
        $display("FAIL wrap_word%0d: got srdy=%b data=%h expected 1 %h", i, p_srdy, p_data,
                 exp_data[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || xfer_cnt !== 16'd3 || p_data !== 8'h01) begin
      errors++;
      $display("FAIL wrap_done: got done=%b cnt=%0d data=%h expected 1 3 01", done, xfer_cnt,
               p_data);
    end
  endtask

  task automatic test_pattern();
    int k = 0;
    srdy_pat = 8'b0101_0101; p_drdy = 1'b1;
    kick(16'd4, 8'h20, 3'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (p_srdy !== ((i % 2) == 0) || (p_srdy && p_data !== 8'(8'h20 + k))) begin
        errors++;
        $display("FAIL pattern_cyc%0d: got srdy=%b data=%h expected %b %h", i, p_srdy, p_data,
                 (i % 2) == 0, 8'(8'h20 + k));
      end
      if (p_srdy) k++;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || p_srdy !== 1'b0 || xfer_cnt !== 16'd4) begin
      errors++;
      $display("FAIL pattern_done: got done=%b srdy=%b cnt=%0d expected 1 0 4", done, p_srdy,
               xfer_cnt);
    end
  endtask

  task automatic test_hold();
    srdy_pat = 8'hFF; p_drdy = 1'b0;
    kick(16'd3, 8'h30, 3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (p_srdy !== 1'b1 || p_data !== 8'h30 || dut.ptr_q !== 3'd1 || xfer_cnt !== 16'd0) begin
        errors++;
        $display("FAIL hold_cyc%0d: got srdy=%b data=%h ptr=%0d cnt=%0d expected 1 30 1 0", i,
                 p_srdy, p_data, dut.ptr_q, xfer_cnt);
      end
    end
    p_drdy = 1'b1;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (p_srdy !== 1'b1 || p_data !== 8'(8'h30 + i) || dut.ptr_q !== 3'(1 + i)) begin
        errors++;
        $display("FAIL hold_resume%0d: got srdy=%b data=%h ptr=%0d expected 1 %h %0d", i, p_srdy,
                 p_data, dut.ptr_q, 8'(8'h30 + i), 1 + i);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || xfer_cnt !== 16'd3) begin
      errors++; $display("FAIL hold_done: got done=%b cnt=%0d expected 1 3", done, xfer_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    srdy_pat = 8'hFF; p_drdy = 1'b1;
    kick(16'd6, 8'h50, 3'd6);
    repeat (3) @(negedge clk);
    checks++;
    if (xfer_cnt !== 16'd2 || p_data !== 8'h52) begin
      errors++; $display("FAIL mid_progress: got cnt=%0d data=%h expected 2 52", xfer_cnt, p_data);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({p_srdy, done, p_data, p_addr, xfer_cnt} !== 29'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got srdy=%b done=%b data=%h addr=%h cnt=%0d expected 0",
               p_srdy, done, p_data, p_addr, xfer_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (p_srdy !== 1'b0 || xfer_cnt !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle_wait: got srdy=%b cnt=%0d done=%b expected 0 0 0", p_srdy, xfer_cnt,
               done);
    end
    kick(16'd2, 8'h40, 3'd4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (p_srdy !== 1'b1 || p_data !== 8'(8'h40 + i)) begin
        errors++;
        $display("FAIL restart_word%0d: got srdy=%b data=%h expected 1 %h", i, p_srdy, p_data,
                 8'(8'h40 + i));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || xfer_cnt !== 16'd2) begin
      errors++; $display("FAIL restart_done: got done=%b cnt=%0d expected 1 2", done, xfer_cnt);
    end
  endtask

  task automatic test_count_zero_and_ignore();
    srdy_pat = 8'hFF; p_drdy = 1'b1;
    kick(16'd0, 8'h77, 3'd7);
    checks++;
    if (p_srdy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_run: got srdy=%b done=%b expected 0 0", p_srdy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || p_srdy !== 1'b0 || xfer_cnt !== 16'd0) begin
        errors++;
        $display("FAIL zero_done%0d: got done=%b srdy=%b cnt=%0d expected 1 0 0", i, done, p_srdy,
                 xfer_cnt);
      end
    end
    kick(16'd3, 8'h60, 3'd2);
    @(negedge clk);
    // Second start while the first word is being accepted must be ignored.
    cfg_count = 16'd1; cfg_seed = 8'h99; cfg_addr = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (p_data !== 8'h61 || p_addr !== 3'd2 || xfer_cnt !== 16'd1 || p_srdy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start: got data=%h addr=%0d cnt=%0d srdy=%b expected 61 2 1 1",
               p_data, p_addr, xfer_cnt, p_srdy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || xfer_cnt !== 16'd3 || p_data !== 8'h63) begin
      errors++;
      $display("FAIL ignore_done: got done=%b cnt=%0d data=%h expected 1 3 63", done, xfer_cnt,
               p_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_pattern();
    test_hold();
    test_reset_mid_run();
    test_count_zero_and_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
